// File: rtl/palette_pkg.sv
// Shared types and the power-on colour table for palette_ram.
// Colour-cycling is compiled in with PALETTE_CYCLE_EN.
package palette_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  localparam int DEF_N = 16;

  localparam logic [23:0] DEFAULT_PALETTE [DEF_N] = '{
    24'hB0B0B0, 24'h0E490A, 24'h1A8512, 24'h21D113,
    24'h0F3D82, 24'h1C70EE, 24'h75A6F0, 24'h801313,
    24'hE60E0E, 24'hFF00FF, 24'h00FFFF, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };

  // Entries past the table are black.
  function automatic logic [23:0] default_rgb(
    input logic [31:0] i
  );
    logic [3:0] k;
    k = i[3:0];
    if (i < DEF_N) return DEFAULT_PALETTE[k];
    return 24'h0;
  endfunction

endpackage

// File: rtl/palette_cycle_ctr.sv
// Frame counter and rotation offset for palette colour-cycling.
// Used only when PALETTE_CYCLE_EN is defined.
module palette_cycle_ctr #(
  parameter int LEN    = 3,
  parameter int PERIOD = 8
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    run_i,
  input  logic                    frame_i,
  input  logic                    en_i,
  output logic [$clog2(LEN)-1:0]  offset_o
);

  localparam int OFF_W = $clog2(LEN);
  localparam int FRM_W = $clog2(PERIOD + 1);

  logic [FRM_W-1:0] frm_q, frm_d;
  logic [OFF_W-1:0] off_q, off_d;

  always_comb begin
    frm_d = frm_q;
    off_d = off_q;
    if (run_i && en_i && frame_i) begin
      if (frm_q == FRM_W'(PERIOD - 1)) begin
        frm_d = '0;
        if (off_q == OFF_W'(LEN - 1)) off_d = '0;
        else off_d = off_q + OFF_W'(1);
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frm_q <= '0;
      off_q <= '0;
    end else begin
      frm_q <= frm_d;
      off_q <= off_d;
    end
  end

  assign offset_o = off_q;

endmodule

// File: rtl/palette_ram.sv
// Writable colour palette with post-reset init and registered lookup.
// Optional colour-cycling over [CYC_LO..CYC_HI]: PALETTE_CYCLE_EN.
module palette_ram
  import palette_pkg::*;
#(
  parameter int IDX_W      = 4,
  parameter int RGB_W      = 24,
  parameter int CYC_LO     = 1,
  parameter int CYC_HI     = 3,
  parameter int CYC_PERIOD = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             rd_valid,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [RGB_W-1:0] wr_rgb,
  input  logic             frame_start,
  input  logic             cyc_en,
  output logic             ready,
  output logic             rgb_valid,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int DEPTH = 1 << IDX_W;

  state_t           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             ready_q;
  logic             vld_q;
  logic [RGB_W-1:0] rgb_q;

  logic [RGB_W-1:0] mem_q [DEPTH];

  logic             we;
  logic [IDX_W-1:0] wa;
  logic [RGB_W-1:0] wd;
  logic             rd_en;
  logic [IDX_W-1:0] raddr;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  // The init sequencer owns the write port until RUN.
  always_comb begin
    we = 1'b0;
    wa = wr_idx;
    wd = wr_rgb;
    if (Reset_n) begin
      if (state_q == INIT) begin
        we = 1'b1;
        wa = cnt_q;
        wd = RGB_W'(default_rgb(32'(cnt_q)));
      end else begin
        we = wr_en;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (we) mem_q[wa] <= wd;
  end

`ifdef PALETTE_CYCLE_EN
  localparam int LEN   = CYC_HI - CYC_LO + 1;
  localparam int OFF_W = $clog2(LEN);

  logic [OFF_W-1:0] offset;

  palette_cycle_ctr #(
    .LEN    (LEN),
    .PERIOD (CYC_PERIOD)
  ) u_cyc (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .run_i    (state_q == RUN),
    .frame_i  (frame_start),
    .en_i     (cyc_en),
    .offset_o (offset)
  );

  // Both terms are below LEN, so one conditional subtract is the modulo.
  always_comb begin
    int rel;
    raddr = rd_idx;
    rel   = int'(rd_idx) - CYC_LO + int'(offset);
    if (int'(rd_idx) >= CYC_LO && int'(rd_idx) <= CYC_HI) begin
      if (rel >= LEN) rel = rel - LEN;
      raddr = IDX_W'(CYC_LO + rel);
    end
  end
`else
  logic unused_cyc;
  assign unused_cyc = ^{frame_start, cyc_en,
                        32'(CYC_LO + CYC_HI + CYC_PERIOD)};
  assign raddr = rd_idx;
`endif

  assign rd_en = rd_valid && (state_q == RUN);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      vld_q <= rd_en;
      if (rd_en) rgb_q <= mem_q[raddr];
    end
  end

  assign ready     = ready_q;
  assign rgb_valid = vld_q;
  assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_palette_ram.sv
// Randomised self-checking bench for palette_ram with a table model.
// Expectations follow PALETTE_CYCLE_EN when it is defined.
module tb_palette_ram;

  localparam int N = 16;

`ifdef PALETTE_CYCLE_EN
  localparam bit CYC = 1'b1;
`else
  localparam bit CYC = 1'b0;
`endif

  localparam logic [23:0] DEF [N] = '{
    24'hB0B0B0, 24'h0E490A, 24'h1A8512, 24'h21D113,
    24'h0F3D82, 24'h1C70EE, 24'h75A6F0, 24'h801313,
    24'hE60E0E, 24'hFF00FF, 24'h00FFFF, 24'h000000,
    24'h000000, 24'h000000, 24'h000000, 24'h000000
  };

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic [3:0]  rd_idx = 4'h0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = 4'h0;
  logic [23:0] wr_rgb = 24'h0;
  logic        frame_start = 1'b0;
  logic        cyc_en = 1'b0;
  logic        ready;
  logic        rgb_valid;
  logic [23:0] rgb_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  palette_ram dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .rd_valid    (rd_valid),
    .rd_idx      (rd_idx),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_rgb      (wr_rgb),
    .frame_start (frame_start),
    .cyc_en      (cyc_en),
    .ready       (ready),
    .rgb_valid   (rgb_valid),
    .rgb_out     (rgb_out)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  logic [23:0] m_mem [N];
  bit          m_ok = 1'b0;
  int          m_init;
  logic        m_ready, m_valid;
  logic [23:0] m_rgb;
  int          m_off, m_frames;

  function automatic int map(input int idx);
    if (CYC && idx >= 1 && idx <= 3) return 1 + (idx - 1 + m_off) % 3;
    return idx;
  endfunction

  initial forever begin
    @(posedge Clk);
    if (!Reset_n) begin
      m_ok = 1'b1;
      m_init = N;
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_rgb = 24'h0;
      m_off = 0;
      m_frames = 0;
      for (int i = 0; i < N; i++) m_mem[i] = DEF[i];
    end else if (m_ok) begin
      if (m_init > 0) begin
        m_init--;
        m_valid = 1'b0;
        m_ready = (m_init == 0);
      end else begin
        m_valid = rd_valid;
        if (rd_valid) m_rgb = m_mem[map(int'(rd_idx))];
        if (wr_en) m_mem[wr_idx] = wr_rgb;
        if (frame_start && cyc_en) begin
          m_frames++;
          if (m_frames == 8) begin
            m_frames = 0;
            m_off = (m_off + 1) % 3;
          end
        end
      end
    end
    #1;
    if (m_ok) begin
      chk("m_ready", 32'(ready), 32'(m_ready));
      chk("m_rgb_valid", 32'(rgb_valid), 32'(m_valid));
      chk("m_rgb_out", 32'(rgb_out), 32'(m_rgb));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic rd(input int idx);
    rd_valid = 1'b1;
    rd_idx = 4'(idx);
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [23:0] v);
    wr_en = 1'b1;
    wr_idx = 4'(idx);
    wr_rgb = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic pulses(input int k);
    for (int i = 0; i < k; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [23:0] e;
    tick(2);
    chk("reset_ready", 32'(ready), 0);
    chk("reset_valid", 32'(rgb_valid), 0);
    chk("reset_rgb", 32'(rgb_out), 0);

    Reset_n = 1'b1;
    wr_en = 1'b1;
    wr_idx = 4'd0;
    wr_rgb = 24'hFFFFFF;
    rd_valid = 1'b1;
    rd_idx = 4'd0;
    wait_ready(n);
    wr_en = 1'b0;
    rd_valid = 1'b0;
    chk("init_len", 32'(n), 16);

    rd(0);
    chk("init_wr_ignored", 32'(rgb_out), 32'h00B0B0B0);
    rd(2);
    chk("rd2_valid", 32'(rgb_valid), 1);
    chk("rd2_rgb", 32'(rgb_out), 32'h001A8512);

    wr(5, 24'h123456);
    rd(5);
    chk("wr5_rd5", 32'(rgb_out), 32'h00123456);

    wr_en = 1'b1;
    wr_idx = 4'd7;
    wr_rgb = 24'hABCDEF;
    rd_valid = 1'b1;
    rd_idx = 4'd7;
    tick();
    wr_en = 1'b0;
    rd_valid = 1'b0;
    chk("rbw_old", 32'(rgb_out), 32'h00801313);
    rd(7);
    chk("rbw_new", 32'(rgb_out), 32'h00ABCDEF);

    for (int i = 0; i < N; i++) begin
      rd_valid = 1'b1;
      rd_idx = 4'(i);
      tick();
      e = (i == 5) ? 24'h123456 : (i == 7) ? 24'hABCDEF : DEF[i];
      chk("stream_valid", 32'(rgb_valid), 1);
      chk("stream_rgb", 32'(rgb_out), 32'(e));
    end
    rd_valid = 1'b0;

    rd(9);
    tick(3);
    chk("idle_valid", 32'(rgb_valid), 0);
    chk("idle_hold", 32'(rgb_out), 32'h00FF00FF);

    rd_valid = 1'b1;
    rd_idx = 4'd1;
    Reset_n = 1'b0;
    tick();
    rd_valid = 1'b0;
    chk("midrun_rst_ready", 32'(ready), 0);
    chk("midrun_rst_valid", 32'(rgb_valid), 0);
    Reset_n = 1'b1;
    wait_ready(n);
    chk("reinit_len", 32'(n), 16);
    rd(5);
    chk("reinit_5", 32'(rgb_out), 32'h001C70EE);
    rd(7);
    chk("reinit_7", 32'(rgb_out), 32'h00801313);

    cyc_en = 1'b1;
    pulses(8);
    rd(1);
    chk("cyc8_idx1", 32'(rgb_out), CYC ? 32'h001A8512 : 32'h000E490A);
    rd(3);
    chk("cyc8_idx3", 32'(rgb_out), CYC ? 32'h000E490A : 32'h0021D113);
    rd(4);
    chk("cyc8_idx4", 32'(rgb_out), 32'h000F3D82);
    cyc_en = 1'b0;
    pulses(8);
    rd(1);
    chk("cyc_frozen", 32'(rgb_out), CYC ? 32'h001A8512 : 32'h000E490A);
    cyc_en = 1'b1;
    pulses(16);
    rd(1);
    chk("cyc24_wrap", 32'(rgb_out), 32'h000E490A);
    wr(2, 24'h445566);
    rd(2);
    chk("cyc_raw_wr", 32'(rgb_out), 32'h00445566);

    for (int i = 0; i < 600; i++) begin
      Reset_n = ($urandom_range(0, 249) != 0);
      rd_valid = 1'(($urandom_range(0, 3) != 0));
      rd_idx = 4'($urandom);
      wr_en = 1'(($urandom_range(0, 2) == 0));
      wr_idx = 4'($urandom);
      wr_rgb = 24'($urandom);
      frame_start = 1'(($urandom_range(0, 2) == 0));
      cyc_en = 1'(($urandom_range(0, 3) != 0));
      tick();
    end

    Reset_n = 1'b1;
    rd_valid = 1'b0;
    wr_en = 1'b0;
    frame_start = 1'b0;
    cyc_en = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
